// File: rtl/cla_add_arbiter_pkg.sv
// rtl/cla_add_arbiter_pkg.sv - shared sizing constants for the CLA add arbiter
// Purpose: default requester count, id width, datapath width, stage split point
//          and CLA group width used by cla_add_arbiter and its helpers.
// Ports:   none (package).
// Build:   the subtract option is enabled by defining CLA_ARB_SUB_EN.
package cla_add_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int DATA_W  = 64;
  localparam int SPLIT   = 32;
  localparam int HI_W    = DATA_W - SPLIT;
  localparam int GRP_W   = 4;

endpackage

// File: rtl/cla_add_arbiter_cla.sv
// rtl/cla_add_arbiter_cla.sv - carry-lookahead adder built from 4-bit lookahead groups
// Purpose: W-bit adder with carry-in and carry-out. Each 4-bit group resolves its
//          internal carries and its group carry in two-level lookahead form.
//          Group carries then chain from group to group.
// Ports:   a, b [W-1:0] operands; cin carry-in; sum [W-1:0]; cout carry out of bit W-1.
// Note:    W must be a multiple of 4.
module cla_add_arbiter_cla #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int NG = W / 4;

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [NG:0]  gc;

  assign g     = a & b;
  assign p     = a ^ b;
  assign gc[0] = cin;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    logic [3:0] gg;
    logic [3:0] pp;
    logic [3:0] c;

    assign gg   = g[4*k +: 4];
    assign pp   = p[4*k +: 4];
    assign c[0] = gc[k];
    assign c[1] = gg[0] | (pp[0] & c[0]);
    assign c[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c[0]);
    assign c[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                | (pp[2] & pp[1] & pp[0] & c[0]);
    // Group generate / propagate folded with the incoming group carry.
    assign gc[k+1] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                   | (pp[3] & pp[2] & pp[1] & gg[0]) | ((&pp) & c[0]);
    assign sum[4*k +: 4] = pp ^ c;
  end

  assign cout = gc[NG];

endmodule

// File: rtl/cla_rr_arbiter.sv
// rtl/cla_rr_arbiter.sv - combinational round-robin grant selection
// Purpose: picks the first asserted request, searching from ptr upward with wrap.
//          The pointer register lives in the parent.
// Ports:   req [N-1:0] request vector; ptr [IDW-1:0] search start;
//          grant [N-1:0] one-hot grant or zero; gnt_idx [IDW-1:0] granted index;
//          gnt_any high when any request was granted.
module cla_rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] gnt_idx,
  output logic           gnt_any
);

  logic [IDW-1:0] j;

  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = '0;
    for (int k = 0; k < N; k++) begin
      j = IDW'((int'(ptr) + k) % N);
      if (!gnt_any && req[j]) begin
        gnt_any = 1'b1;
        gnt_idx = j;
      end
    end
    grant[gnt_idx] = gnt_any;
  end

endmodule

// File: rtl/cla_add_arbiter.sv
// rtl/cla_add_arbiter.sv - round-robin shared 2-stage CLA add pipeline
// Purpose: grants one of NUM_REQ requesters per cycle. Stage 1 adds the low SPLIT
//          bits and registers the split carry. Stage 2 adds the high half and
//          presents the sum tagged with the requester id. The whole pipe stalls
//          while a result waits on res_ready.
// Ports:   clk, rst_n (sync active-low); req_valid/req_ready [NUM_REQ];
//          req_a/req_b [NUM_REQ*DATA_W] packed per requester; req_cin [NUM_REQ];
//          req_sub [NUM_REQ] (only with CLA_ARB_SUB_EN); res_valid/res_ready;
//          res_id [ID_W]; res_sum [DATA_W]; res_cout.
// Build:   define CLA_ARB_SUB_EN to add per-requester subtract (A + ~B + 1).
module cla_add_arbiter
  import cla_add_arbiter_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]        req_cin,
`ifdef CLA_ARB_SUB_EN
  input  logic [NUM_REQ-1:0]        req_sub,
`endif
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [ID_W-1:0]           res_id,
  output logic [DATA_W-1:0]         res_sum,
  output logic                      res_cout
);

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;
  logic               adv;
  logic               hs;
  logic [DATA_W-1:0]  op_a;
  logic [DATA_W-1:0]  op_b;
  logic               op_cin;
  logic [SPLIT-1:0]   lo_sum;
  logic               lo_cout;
  logic [HI_W-1:0]    hi_sum;
  logic               hi_cout;

  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              s1_vld_q, s1_vld_d;
  logic [SPLIT-1:0]  s1_lo_q, s1_lo_d;
  logic              s1_c_q, s1_c_d;
  logic [HI_W-1:0]   s1_a_hi_q, s1_a_hi_d;
  logic [HI_W-1:0]   s1_b_hi_q, s1_b_hi_d;
  logic [ID_W-1:0]   s1_id_q, s1_id_d;
  logic              res_valid_q, res_valid_d;
  logic [ID_W-1:0]   res_id_q, res_id_d;
  logic [DATA_W-1:0] res_sum_q, res_sum_d;
  logic              res_cout_q, res_cout_d;

  cla_rr_arbiter #(.N(NUM_REQ), .IDW(ID_W)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .grant   (grant),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // The pipe moves only when the output slot is free or being drained.
  assign adv       = !res_valid_q || res_ready;
  assign hs        = adv && gnt_any;
  assign req_ready = grant & {NUM_REQ{adv}};

  always_comb begin
    op_a   = req_a[gnt_idx*DATA_W +: DATA_W];
    op_b   = req_b[gnt_idx*DATA_W +: DATA_W];
    op_cin = req_cin[gnt_idx];
`ifdef CLA_ARB_SUB_EN
    // Two's-complement subtract: invert B and force the carry-in.
    if (req_sub[gnt_idx]) begin
      op_b   = ~op_b;
      op_cin = 1'b1;
    end
`endif
  end

  cla_add_arbiter_cla #(.W(SPLIT)) u_add_lo (
    .a    (op_a[SPLIT-1:0]),
    .b    (op_b[SPLIT-1:0]),
    .cin  (op_cin),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  cla_add_arbiter_cla #(.W(HI_W)) u_add_hi (
    .a    (s1_a_hi_q),
    .b    (s1_b_hi_q),
    .cin  (s1_c_q),
    .sum  (hi_sum),
    .cout (hi_cout)
  );

  always_comb begin
    ptr_d       = ptr_q;
    s1_vld_d    = s1_vld_q;
    s1_lo_d     = s1_lo_q;
    s1_c_d      = s1_c_q;
    s1_a_hi_d   = s1_a_hi_q;
    s1_b_hi_d   = s1_b_hi_q;
    s1_id_d     = s1_id_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_sum_d   = res_sum_q;
    res_cout_d  = res_cout_q;
    if (adv) begin
      s1_vld_d    = hs;
      res_valid_d = s1_vld_q;
      if (hs) begin
        s1_lo_d   = lo_sum;
        s1_c_d    = lo_cout;
        s1_a_hi_d = op_a[DATA_W-1:SPLIT];
        s1_b_hi_d = op_b[DATA_W-1:SPLIT];
        s1_id_d   = gnt_idx;
        ptr_d     = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
      end
      if (s1_vld_q) begin
        res_sum_d  = {hi_sum, s1_lo_q};
        res_cout_d = hi_cout;
        res_id_d   = s1_id_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      s1_vld_q    <= 1'b0;
      s1_lo_q     <= '0;
      s1_c_q      <= 1'b0;
      s1_a_hi_q   <= '0;
      s1_b_hi_q   <= '0;
      s1_id_q     <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_sum_q   <= '0;
      res_cout_q  <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      s1_vld_q    <= s1_vld_d;
      s1_lo_q     <= s1_lo_d;
      s1_c_q      <= s1_c_d;
      s1_a_hi_q   <= s1_a_hi_d;
      s1_b_hi_q   <= s1_b_hi_d;
      s1_id_q     <= s1_id_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_sum_q   <= res_sum_d;
      res_cout_q  <= res_cout_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;

endmodule

// File: tb/tb_cla_add_arbiter.sv
// tb/tb_cla_add_arbiter.sv - directed self-checking bench for cla_add_arbiter
module tb_cla_add_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [255:0] req_a;
  logic [255:0] req_b;
  logic [3:0]   req_cin;
`ifdef CLA_ARB_SUB_EN
  logic [3:0]   req_sub;
`endif
  logic         res_valid;
  logic         res_ready;
  logic [1:0]   res_id;
  logic [63:0]  res_sum;
  logic         res_cout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cla_add_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
`ifdef CLA_ARB_SUB_EN
    .req_sub   (req_sub),
`endif
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_sum   (res_sum),
    .res_cout  (res_cout)
  );

  // Reference add from the operands the bench itself drives: {cout, sum}.
  function automatic logic [64:0] model(int i);
    return {1'b0, req_a[i*64 +: 64]} + {1'b0, req_b[i*64 +: 64]} + {64'd0, req_cin[i]};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 4'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic load_stream_ops();
    for (int i = 0; i < 4; i++) begin
      req_a[i*64 +: 64] = 64'h1111_1111_FFFF_FFF0 + 64'(i);
      req_b[i*64 +: 64] = 64'h0000_0000_0000_0010 * 64'(i + 1);
      req_cin[i]        = i[0];
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'b0;
    tick();
    tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", res_valid); end
    checks++; if (res_sum !== 64'd0) begin errors++; $display("FAIL reset_sum got=%h exp=0", res_sum); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL reset_id got=%0d exp=0", res_id); end
    checks++; if (res_cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", res_cout); end
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_add();
    req_a[63:0] = 64'h0000_0000_FFFF_FFFF;
    req_b[63:0] = 64'd1;
    req_cin[0]  = 1'b0;
    req_valid   = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
    tick();
    req_valid = 4'b0;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_early got=%b exp=0", res_valid); end
    tick();
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", res_valid); end
    checks++; if (res_sum !== 64'h0000_0001_0000_0000) begin errors++; $display("FAIL single_sum got=%h exp=0000000100000000", res_sum); end
    checks++; if (res_cout !== 1'b0) begin errors++; $display("FAIL single_cout got=%b exp=0", res_cout); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL single_id got=%0d exp=0", res_id); end
    tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_drain got=%b exp=0", res_valid); end
  endtask

  task automatic test_full_wrap();
    // Pointer sits at 1 after the previous grant; requester 2 is next in line.
    req_a[128 +: 64] = 64'hFFFF_FFFF_FFFF_FFFF;
    req_b[128 +: 64] = 64'd0;
    req_cin[2]       = 1'b1;
    req_valid        = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL wrap_ready got=%b exp=0100", req_ready); end
    tick();
    req_valid = 4'b0;
    tick();
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got=%b exp=1", res_valid); end
    checks++; if (res_sum !== 64'd0) begin errors++; $display("FAIL wrap_sum got=%h exp=0", res_sum); end
    checks++; if (res_cout !== 1'b1) begin errors++; $display("FAIL wrap_cout got=%b exp=1", res_cout); end
    checks++; if (res_id !== 2'd2) begin errors++; $display("FAIL wrap_id got=%0d exp=2", res_id); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_rdy;
    logic [1:0]  exp_id;
    logic [64:0] exp_r;
    do_reset();
    load_stream_ops();
    res_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      req_valid = (k < 8) ? 4'b1111 : 4'b0000;
      #1;
      exp_rdy = (k < 8) ? 4'(1 << (k % 4)) : 4'b0000;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready cyc=%0d got=%b exp=%b", k, req_ready, exp_rdy); end
      if (k >= 2) begin
        exp_id = 2'((k - 2) % 4);
        exp_r  = model(int'(exp_id));
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL rr_valid cyc=%0d got=%b exp=1", k, res_valid); end
        checks++; if (res_id !== exp_id) begin errors++; $display("FAIL rr_id cyc=%0d got=%0d exp=%0d", k, res_id, exp_id); end
        checks++; if ({res_cout, res_sum} !== exp_r) begin errors++; $display("FAIL rr_sum cyc=%0d got=%b_%h exp=%b_%h", k, res_cout, res_sum, exp_r[64], exp_r[63:0]); end
      end else begin
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rr_fill cyc=%0d got=%b exp=0", k, res_valid); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [3:0]  exp_rdy [9] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
    logic        exp_rv  [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0]  exp_id  [9] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0};
    logic [64:0] exp_r;
    do_reset();
    load_stream_ops();
    for (int k = 0; k < 9; k++) begin
      req_valid = (k <= 5) ? 4'b1111 : 4'b0000;
      res_ready = (k >= 2 && k <= 4) ? 1'b0 : 1'b1;
      #1;
      checks++; if (req_ready !== exp_rdy[k]) begin errors++; $display("FAIL bp_ready cyc=%0d got=%b exp=%b", k, req_ready, exp_rdy[k]); end
      checks++; if (res_valid !== exp_rv[k]) begin errors++; $display("FAIL bp_valid cyc=%0d got=%b exp=%b", k, res_valid, exp_rv[k]); end
      if (exp_rv[k]) begin
        exp_r = model(int'(exp_id[k]));
        checks++; if (res_id !== exp_id[k]) begin errors++; $display("FAIL bp_id cyc=%0d got=%0d exp=%0d", k, res_id, exp_id[k]); end
        checks++; if ({res_cout, res_sum} !== exp_r) begin errors++; $display("FAIL bp_sum cyc=%0d got=%b_%h exp=%b_%h", k, res_cout, res_sum, exp_r[64], exp_r[63:0]); end
      end
      tick();
    end
    res_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_stream_ops();
    res_ready = 1'b1;
    req_valid = 4'b1111;
    tick();
    tick();
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL mid_pre got=%b exp=1", res_valid); end
    rst_n = 1'b0;
    req_valid = 4'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", res_valid); end
    checks++; if (res_sum !== 64'd0) begin errors++; $display("FAIL mid_sum got=%h exp=0", res_sum); end
    tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL mid_stale1 got=%b exp=0", res_valid); end
    tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL mid_stale2 got=%b exp=0", res_valid); end
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_ptr got=%b exp=0001", req_ready); end
    req_valid = 4'b0;
    tick();
  endtask

`ifdef CLA_ARB_SUB_EN
  task automatic test_sub();
    do_reset();
    req_a[192 +: 64] = 64'd5;
    req_b[192 +: 64] = 64'd7;
    req_cin[3]       = 1'b0;
    req_sub          = 4'b1000;
    req_valid        = 4'b1000;
    tick();
    req_valid = 4'b0;
    tick();
    checks++; if (res_sum !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL sub_neg_sum got=%h exp=fffffffffffffffe", res_sum); end
    checks++; if (res_cout !== 1'b0) begin errors++; $display("FAIL sub_neg_cout got=%b exp=0", res_cout); end
    checks++; if (res_id !== 2'd3) begin errors++; $display("FAIL sub_id got=%0d exp=3", res_id); end
    tick();
    req_a[192 +: 64] = 64'd7;
    req_b[192 +: 64] = 64'd5;
    req_valid        = 4'b1000;
    tick();
    req_valid = 4'b0;
    tick();
    checks++; if (res_sum !== 64'd2) begin errors++; $display("FAIL sub_pos_sum got=%h exp=2", res_sum); end
    checks++; if (res_cout !== 1'b1) begin errors++; $display("FAIL sub_pos_cout got=%b exp=1", res_cout); end
    tick();
    req_sub = 4'b0;
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = 4'b0;
    res_ready = 1'b1;
`ifdef CLA_ARB_SUB_EN
    req_sub   = 4'b0;
`endif
    @(negedge clk);
    test_reset();
    test_single_add();
    test_full_wrap();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
`ifdef CLA_ARB_SUB_EN
    test_sub();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
